// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter: burst scheduler for the SDRAM controller.
// Arbitrates NUM_RD read-side and NUM_WR write-side FIFOs, keeps a wrapping
// burst address per port and issues one burst request at a time.
//
// Ports:
//   CTRL_CLK, RESET            clock, asynchronous active-high reset
//   WR_LOAD/BASE/MAX/LENGTH    per-port write config (packed, port 0 in LSBs)
//   WR_USEDW                   used words of each write FIFO
//   RD_LOAD/BASE/MAX/LENGTH    per-port read config (same shapes)
//   RD_USEDW                   used words of each read FIFO
//   BURST_DONE                 one-cycle end-of-burst pulse from the command layer
//   REQ_WR/REQ_RD              burst request level, held until BURST_DONE
//   REQ_ADDR/REQ_LENGTH        burst start address and length
//   WR_SEL/RD_SEL              one-hot granted port
//
// Build option: define SDRAM_ARB_ROUND_ROBIN_EN for round-robin grant over
// the combined index space (reads first, then writes); otherwise fixed
// priority, reads before writes, lowest index first.
module sdram_burst_arbiter #(
   parameter int unsigned ASIZE  = 22,
   parameter int unsigned LSIZE  = 10,
   parameter int unsigned USEDW  = 16,
   parameter int unsigned NUM_WR = 2,
   parameter int unsigned NUM_RD = 2
) (
   input  logic                    CTRL_CLK,
   input  logic                    RESET,
   input  logic [NUM_WR-1:0]       WR_LOAD,
   input  logic [NUM_WR*ASIZE-1:0] WR_BASE,
   input  logic [NUM_WR*ASIZE-1:0] WR_MAX,
   input  logic [NUM_WR*LSIZE-1:0] WR_LENGTH,
   input  logic [NUM_WR*USEDW-1:0] WR_USEDW,
   input  logic [NUM_RD-1:0]       RD_LOAD,
   input  logic [NUM_RD*ASIZE-1:0] RD_BASE,
   input  logic [NUM_RD*ASIZE-1:0] RD_MAX,
   input  logic [NUM_RD*LSIZE-1:0] RD_LENGTH,
   input  logic [NUM_RD*USEDW-1:0] RD_USEDW,
   input  logic                    BURST_DONE,
   output logic                    REQ_WR,
   output logic                    REQ_RD,
   output logic [ASIZE-1:0]        REQ_ADDR,
   output logic [LSIZE-1:0]        REQ_LENGTH,
   output logic [NUM_WR-1:0]       WR_SEL,
   output logic [NUM_RD-1:0]       RD_SEL
);

   localparam int unsigned NP = NUM_RD + NUM_WR;
   localparam int unsigned IW = $clog2(NP);
   localparam int unsigned CW = (USEDW > LSIZE) ? USEDW : LSIZE;
   localparam int unsigned AW = ASIZE + 1;

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BUSY, ST_HOLD} state_e;

   state_e              state_q, state_d;
   logic [IW-1:0]       gnt_q, gnt_d;
   logic                req_wr_q, req_wr_d, req_rd_q, req_rd_d;
   logic [ASIZE-1:0]    req_addr_q, req_addr_d;
   logic [LSIZE-1:0]    req_len_q, req_len_d;
   logic [NP-1:0]       sel_q, sel_d;
   logic [NP*ASIZE-1:0] addr_q, addr_d;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   logic [IW-1:0]       ptr_q, ptr_d;
`endif

   // Per-port views over the combined index space: reads 0..NUM_RD-1, then writes
   logic [ASIZE-1:0] base_a [NP];
   logic [ASIZE-1:0] max_a  [NP];
   logic [LSIZE-1:0] len_a  [NP];
   logic [ASIZE-1:0] addr_a [NP];
   logic [AW-1:0]    nxt_a  [NP];
   logic [ASIZE-1:0] adv_a  [NP];
   logic [NP-1:0]    load_v, elig_v;
   logic             found_c, adv_c, init_c;
   logic [IW-1:0]    pick_c;
   int unsigned      idx;

   genvar g;
   generate
      for (g = 0; g < NUM_RD; g++) begin : g_rd
         assign base_a[g] = RD_BASE[g*ASIZE +: ASIZE];
         assign max_a[g]  = RD_MAX[g*ASIZE +: ASIZE];
         assign len_a[g]  = RD_LENGTH[g*LSIZE +: LSIZE];
         assign load_v[g] = RD_LOAD[g];
         // Read FIFO has room for a whole burst
         assign elig_v[g] = (CW'(RD_USEDW[g*USEDW +: USEDW]) < CW'(RD_LENGTH[g*LSIZE +: LSIZE]))
                            && (RD_LENGTH[g*LSIZE +: LSIZE] != '0);
      end
      for (g = 0; g < NUM_WR; g++) begin : g_wr
         assign base_a[NUM_RD+g] = WR_BASE[g*ASIZE +: ASIZE];
         assign max_a[NUM_RD+g]  = WR_MAX[g*ASIZE +: ASIZE];
         assign len_a[NUM_RD+g]  = WR_LENGTH[g*LSIZE +: LSIZE];
         assign load_v[NUM_RD+g] = WR_LOAD[g];
         // Write FIFO holds a whole burst of data
         assign elig_v[NUM_RD+g] = (CW'(WR_USEDW[g*USEDW +: USEDW]) >= CW'(WR_LENGTH[g*LSIZE +: LSIZE]))
                                   && (WR_LENGTH[g*LSIZE +: LSIZE] != '0);
      end
      // Address update: INIT/LOAD reload BASE and win over a burst-end advance
      for (g = 0; g < NP; g++) begin : g_addr
         assign addr_a[g] = addr_q[g*ASIZE +: ASIZE];
         assign nxt_a[g]  = AW'(addr_a[g]) + AW'(len_a[g]);
         assign adv_a[g]  = (nxt_a[g] < AW'(max_a[g])) ? nxt_a[g][ASIZE-1:0] : base_a[g];
         assign addr_d[g*ASIZE +: ASIZE] = (init_c || load_v[g]) ? base_a[g] :
                                           (adv_c && (gnt_q == IW'(g))) ? adv_a[g] : addr_a[g];
      end
   endgenerate

   assign init_c = (state_q == ST_INIT);

   // Grant search: first eligible index starting at the pointer (or at 0)
   always_comb begin
      found_c = 1'b0;
      pick_c  = '0;
      idx     = 0;
      for (int unsigned k = 0; k < NP; k++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
         idx = 32'(ptr_q) + k;
         if (idx >= NP) idx = idx - NP;
`else
         idx = k;
`endif
         if (!found_c && elig_v[IW'(idx)]) begin
            found_c = 1'b1;
            pick_c  = IW'(idx);
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      req_wr_d   = req_wr_q;
      req_rd_d   = req_rd_q;
      req_addr_d = req_addr_q;
      req_len_d  = req_len_q;
      sel_d      = sel_q;
      adv_c      = 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      ptr_d      = ptr_q;
`endif
      case (state_q)
         ST_INIT: state_d = ST_IDLE;
         ST_IDLE: begin
            if (!(|load_v) && found_c) begin
               state_d    = ST_BUSY;
               gnt_d      = pick_c;
               req_addr_d = addr_a[pick_c];
               req_len_d  = len_a[pick_c];
               sel_d      = NP'(1) << pick_c;
               req_rd_d   = (32'(pick_c) < NUM_RD);
               req_wr_d   = (32'(pick_c) >= NUM_RD);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
               ptr_d      = (32'(pick_c) + 1 >= NP) ? '0 : pick_c + IW'(1);
`endif
            end
         end
         ST_BUSY: begin
            if (BURST_DONE) begin
               state_d    = ST_HOLD;
               adv_c      = 1'b1;
               req_wr_d   = 1'b0;
               req_rd_d   = 1'b0;
               req_addr_d = '0;
               req_len_d  = '0;
               sel_d      = '0;
            end
         end
         ST_HOLD: state_d = ST_IDLE;
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge CTRL_CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_INIT;
         gnt_q      <= '0;
         req_wr_q   <= 1'b0;
         req_rd_q   <= 1'b0;
         req_addr_q <= '0;
         req_len_q  <= '0;
         sel_q      <= '0;
         addr_q     <= '0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
         ptr_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         req_wr_q   <= req_wr_d;
         req_rd_q   <= req_rd_d;
         req_addr_q <= req_addr_d;
         req_len_q  <= req_len_d;
         sel_q      <= sel_d;
         addr_q     <= addr_d;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
         ptr_q      <= ptr_d;
`endif
      end
   end

   assign REQ_WR     = req_wr_q;
   assign REQ_RD     = req_rd_q;
   assign REQ_ADDR   = req_addr_q;
   assign REQ_LENGTH = req_len_q;
   assign RD_SEL     = sel_q[NUM_RD-1:0];
   assign WR_SEL     = sel_q[NP-1:NUM_RD];

endmodule
